// File: rtl/dcache_arb_pkg.sv
// Shared types and the round-robin pick helper for the dcache port arbiter.
package dcache_arb_pkg;

  // Owner field sized for the largest supported requester count (8 ports).
  localparam int unsigned MaxPorts   = 8;
  localparam int unsigned OwnerWidth = 3;

  typedef struct packed {
    logic                  valid;
    logic [OwnerWidth-1:0] owner;
  } tid_entry_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // First requesting port at or after ptr, wrapping modulo n.
  function automatic logic [OwnerWidth-1:0] rr_pick(
    input logic [MaxPorts-1:0]   req,
    input logic [OwnerWidth-1:0] ptr,
    input int unsigned           n
  );
    logic [OwnerWidth-1:0] sel;
    int unsigned           idx;
    sel = '0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int unsigned i = n; i > 0; i--) begin
      idx = (32'(ptr) + i - 1) % n;
      if (req[idx]) sel = OwnerWidth'(idx);
    end
    return sel;
  endfunction

endpackage

// File: rtl/dcache_arb_tid_table.sv
// Transaction-ID table: lowest-free allocation, response lookup and release.
module dcache_arb_tid_table
  import dcache_arb_pkg::*;
#(
  parameter int unsigned TidWidth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_i,
  input  logic [TidWidth-1:0]   alloc_tid_i,
  input  logic [OwnerWidth-1:0] alloc_owner_i,
  input  logic                  rsp_valid_i,
  input  logic [TidWidth-1:0]   rsp_tid_i,
  output logic [TidWidth-1:0]   free_tid_o,
  output logic                  full_o,
  output logic                  busy_o,
  output logic                  rsp_hit_o,
  output logic [OwnerWidth-1:0] rsp_owner_o
);

  localparam int unsigned NrEntries = 2 ** TidWidth;

  tid_entry_t table_q [NrEntries];

  always_comb begin
    free_tid_o = '0;
    full_o     = 1'b1;
    busy_o     = 1'b0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      busy_o = busy_o | table_q[i].valid;
      if (!table_q[i].valid && full_o) begin
        free_tid_o = TidWidth'(i);
        full_o     = 1'b0;
      end
    end
  end

  assign rsp_hit_o   = rsp_valid_i && table_q[rsp_tid_i].valid;
  assign rsp_owner_o = table_q[rsp_tid_i].owner;

  // The allocated tid is always a currently free entry, so release and
  // allocation in the same cycle never target the same slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrEntries; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      if (rsp_hit_o) table_q[rsp_tid_i].valid <= 1'b0;
      if (alloc_i) begin
        table_q[alloc_tid_i].valid <= 1'b1;
        table_q[alloc_tid_i].owner <= alloc_owner_i;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one dcache request port, with tid-based response routing.
// Optional contention counter enabled by defining DCACHE_ARB_PERF_EN.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NrPorts   = 3,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrPorts-1:0]             req_i,
  input  logic [NrPorts*AddrWidth-1:0]   addr_i,
  input  logic [NrPorts-1:0]             we_i,
  input  logic [NrPorts*DataWidth-1:0]   wdata_i,
  input  logic [NrPorts*DataWidth/8-1:0] be_i,
  output logic [NrPorts-1:0]             gnt_o,
  output logic [NrPorts-1:0]             rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           mem_req_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic                           mem_we_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [DataWidth/8-1:0]         mem_be_o,
  output logic [TidWidth-1:0]            mem_tid_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [TidWidth-1:0]            mem_rid_i,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [31:0]                    conflict_cnt_o
);

  localparam int unsigned PortBits = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned BeWidth  = DataWidth / 8;

  arb_state_e            state_q;
  logic [PortBits-1:0]   rr_ptr_q;
  logic [PortBits-1:0]   sel_q;
  logic [TidWidth-1:0]   tid_q;

  logic [MaxPorts-1:0]   req_pad;
  logic [OwnerWidth-1:0] ptr_pad;
  logic [OwnerWidth-1:0] pick_full;
  logic [PortBits-1:0]   pick;
  logic                  cur_valid;
  logic [PortBits-1:0]   cur_sel;
  logic [TidWidth-1:0]   cur_tid;
  logic [PortBits-1:0]   next_ptr;
  logic                  alloc;

  logic [TidWidth-1:0]   free_tid;
  logic                  full;
  logic                  rsp_hit;
  logic [OwnerWidth-1:0] rsp_owner;

  always_comb begin
    req_pad              = '0;
    req_pad[NrPorts-1:0] = req_i;
    ptr_pad              = '0;
    ptr_pad[PortBits-1:0] = rr_ptr_q;
    pick_full            = rr_pick(req_pad, ptr_pad, NrPorts);
    pick                 = '0;
    for (int unsigned k = 0; k < NrPorts; k++) begin
      if (pick_full == OwnerWidth'(k)) pick = PortBits'(k);
    end
  end

  // LOCKED replays the registered choice so the handshake cannot switch ports.
  always_comb begin
    if (state_q == LOCKED) begin
      cur_valid = 1'b1;
      cur_sel   = sel_q;
      cur_tid   = tid_q;
    end else begin
      cur_valid = (|req_i) && !full;
      cur_sel   = pick;
      cur_tid   = free_tid;
    end
    alloc    = cur_valid && mem_gnt_i;
    next_ptr = (cur_sel == PortBits'(NrPorts - 1)) ? '0 : cur_sel + 1'b1;
  end

  always_comb begin
    gnt_o       = '0;
    mem_req_o   = cur_valid;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    mem_tid_o   = cur_valid ? cur_tid : '0;
    if (cur_valid) begin
      for (int unsigned k = 0; k < NrPorts; k++) begin
        if (cur_sel == PortBits'(k)) begin
          mem_addr_o  = addr_i[k*AddrWidth +: AddrWidth];
          mem_we_o    = we_i[k];
          mem_wdata_o = wdata_i[k*DataWidth +: DataWidth];
          mem_be_o    = be_i[k*BeWidth +: BeWidth];
          gnt_o[k]    = mem_gnt_i;
        end
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int unsigned k = 0; k < NrPorts; k++) begin
      rvalid_o[k] = rsp_hit && (rsp_owner == OwnerWidth'(k));
    end
    rdata_o = rsp_hit ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      tid_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cur_valid) begin
            if (mem_gnt_i) begin
              rr_ptr_q <= next_ptr;
            end else begin
              state_q <= LOCKED;
              sel_q   <= cur_sel;
              tid_q   <= cur_tid;
            end
          end
        end
        LOCKED: begin
          if (mem_gnt_i) begin
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (mem_rvalid_i && !rsp_hit) begin
      err_o <= 1'b1;
    end
  end

  dcache_arb_tid_table #(
    .TidWidth (TidWidth)
  ) u_tid_table (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (alloc),
    .alloc_tid_i   (cur_tid),
    .alloc_owner_i (OwnerWidth'(cur_sel)),
    .rsp_valid_i   (mem_rvalid_i),
    .rsp_tid_i     (mem_rid_i),
    .free_tid_o    (free_tid),
    .full_o        (full),
    .busy_o        (busy_o),
    .rsp_hit_o     (rsp_hit),
    .rsp_owner_o   (rsp_owner)
  );

`ifdef DCACHE_ARB_PERF_EN
  logic        multi_req;
  logic [31:0] conflict_q;

  assign multi_req      = $countones(req_i) > 1;
  assign conflict_cnt_o = conflict_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_q <= '0;
    end else if (multi_req && (conflict_q != '1)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end
`else
  assign conflict_cnt_o = '0;
`endif

endmodule
